// File: rtl/cache_nway_wb_pkg.sv
// rtl/cache_nway_wb_pkg.sv - shared FSM encoding and geometry helpers for the N-way cache
package cache_nway_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_t;

  function automatic int num_sets(input int cache_size, input int block_size, input int num_ways);
    return cache_size / (block_size * num_ways);
  endfunction

endpackage

// File: rtl/cache_nway_wb_if.sv
// rtl/cache_nway_wb_if.sv - requester-side and memory-side bus interfaces of the cache
interface cache_cpu_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  hit;

  modport master (output req, we, addr, wdata, input ready, resp_valid, rdata, hit);
  modport slave  (input req, we, addr, wdata, output ready, resp_valid, rdata, hit);
endinterface

interface cache_mem_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/cache_nway_wb_lru_age_nway.sv
// rtl/cache_nway_wb_lru_age_nway.sv - true-LRU age vector for one set
module lru_age_nway #(
  parameter int NUM_WAYS = 4,
  localparam int AGE_W   = $clog2(NUM_WAYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      touch_en,
  input  logic [AGE_W-1:0]          touch_way,
  output logic [AGE_W-1:0]          victim_way,
  output logic [NUM_WAYS*AGE_W-1:0] ages
);

  logic [AGE_W-1:0] touched_age;

  assign touched_age = ages[touch_way*AGE_W +: AGE_W];

  // Ages stay a permutation: the touched way becomes 0 and only younger ways shift up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) ages[w*AGE_W +: AGE_W] <= AGE_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == touch_way)
          ages[w*AGE_W +: AGE_W] <= '0;
        else if (ages[w*AGE_W +: AGE_W] < touched_age)
          ages[w*AGE_W +: AGE_W] <= ages[w*AGE_W +: AGE_W] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (ages[w*AGE_W +: AGE_W] == AGE_W'(NUM_WAYS - 1)) victim_way = AGE_W'(w);
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// rtl/cache_nway_wb.sv - N-way set-associative write-back/write-allocate cache with true LRU
module cache_nway_wb
  import cache_nway_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CACHE_SIZE = 512,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_cpu_if.slave           cpu,
  cache_mem_if.master          mem,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int NUM_SETS = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  state_t state;

  logic                  line_valid [NUM_SETS][NUM_WAYS];
  logic                  line_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      line_tag   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] line_data  [NUM_SETS][NUM_WAYS];

  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [TAG_W-1:0]      lat_tag;
  logic [INDEX_W-1:0]    lat_index;
  logic [WAY_W-1:0]      lat_way;

  logic [INDEX_W-1:0]    req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_found;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim_way;
  logic                  accept;
  logic                  fill_done;
  logic [WAY_W-1:0]      touch_way;
  logic [NUM_SETS-1:0]   touch_en;

  logic [WAY_W-1:0]          lru_victim [NUM_SETS];
  logic [NUM_WAYS*WAY_W-1:0] set_ages   [NUM_SETS];

  assign req_index = cpu.addr[OFFSET_W +: INDEX_W];
  assign req_tag   = cpu.addr[ADDR_WIDTH-1 -: TAG_W];
  assign accept    = cpu.req && cpu.ready;
  assign fill_done = (state == REFILL) && mem.ready;
  assign touch_way = fill_done ? lat_way : hit_way;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!line_valid[req_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (line_valid[req_index][w] && line_tag[req_index][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign victim_way = inv_found ? inv_way : lru_victim[req_index];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    assign touch_en[s] = (accept && hit && req_index == INDEX_W'(s)) ||
                         (fill_done && lat_index == INDEX_W'(s));
    lru_age_nway #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk       (clk),
      .rst       (rst),
      .touch_en  (touch_en[s]),
      .touch_way (touch_way),
      .victim_way(lru_victim[s]),
      .ages      (set_ages[s])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cpu.ready      <= 1'b1;
      cpu.resp_valid <= 1'b0;
      cpu.rdata      <= '0;
      cpu.hit        <= 1'b0;
      mem.req        <= 1'b0;
      mem.we         <= 1'b0;
      mem.addr       <= '0;
      mem.wdata      <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
      lat_we         <= 1'b0;
      lat_wdata      <= '0;
      lat_tag        <= '0;
      lat_index      <= '0;
      lat_way        <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          line_valid[s][w] <= 1'b0;
          line_dirty[s][w] <= 1'b0;
          line_tag[s][w]   <= '0;
          line_data[s][w]  <= '0;
        end
      end
    end else begin
      cpu.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && hit) begin
            cpu.resp_valid <= 1'b1;
            cpu.hit        <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            if (cpu.we) begin
              line_data[req_index][hit_way]  <= cpu.wdata;
              line_dirty[req_index][hit_way] <= 1'b1;
              cpu.rdata                      <= cpu.wdata;
            end else begin
              cpu.rdata <= line_data[req_index][hit_way];
            end
          end else if (accept) begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            lat_we    <= cpu.we;
            lat_wdata <= cpu.wdata;
            lat_tag   <= req_tag;
            lat_index <= req_index;
            lat_way   <= victim_way;
            cpu.ready <= 1'b0;
            mem.req   <= 1'b1;
            if (line_valid[req_index][victim_way] && line_dirty[req_index][victim_way]) begin
              state     <= WB;
              mem.we    <= 1'b1;
              mem.addr  <= {line_tag[req_index][victim_way], req_index, {OFFSET_W{1'b0}}};
              mem.wdata <= line_data[req_index][victim_way];
            end else begin
              state    <= REFILL;
              mem.we   <= 1'b0;
              mem.addr <= {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (mem.ready) begin
            state    <= REFILL;
            mem.we   <= 1'b0;
            mem.addr <= {lat_tag, lat_index, {OFFSET_W{1'b0}}};
          end
        end
        REFILL: begin
          if (mem.ready) begin
            // A write miss replaces the whole one-word line, so refill data is discarded.
            line_valid[lat_index][lat_way] <= 1'b1;
            line_dirty[lat_index][lat_way] <= lat_we;
            line_tag[lat_index][lat_way]   <= lat_tag;
            line_data[lat_index][lat_way]  <= lat_we ? lat_wdata : mem.rdata;
            cpu.rdata                      <= lat_we ? lat_wdata : mem.rdata;
            cpu.resp_valid                 <= 1'b1;
            cpu.hit                        <= 1'b0;
            cpu.ready                      <= 1'b1;
            mem.req                        <= 1'b0;
            state                          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_nway_wb.sv
// tb/tb_cache_nway_wb.sv - directed table-driven bench for cache_nway_wb
module tb_cache_nway_wb;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct {
    logic          rst_before;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_hit;
    logic [DW-1:0] exp_rdata;
    int            exp_hits;
    int            exp_misses;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_cpu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu ();
  cache_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  cache_nway_wb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_SIZE(512),
    .BLOCK_SIZE(32), .NUM_WAYS(4), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu),
    .mem       (mem),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stall    = 0;
  int cyc      = 0;
  int wb_count = 0;
  int wb_cyc   = 0;
  int refill_cyc = 0;
  logic [AW-1:0] wb_addr = '0;
  logic [AW-1:0] refill_addr = '0;
  logic [DW-1:0] wb_data = '0;

  vec_t vecs [18];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [DW-1:0] base;
    base = 32'h11111111;
    return base * ({28'd0, a[10:7]} + 32'd1);
  endfunction

  function automatic vec_t mk(input logic r, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic h, input logic [DW-1:0] rd,
                              input int eh, input int em);
    vec_t v;
    v.rst_before = r; v.we = we; v.addr = a; v.wdata = wd;
    v.exp_hit = h; v.exp_rdata = rd; v.exp_hits = eh; v.exp_misses = em;
    return v;
  endfunction

  // Memory model: ready one cycle after it sees mem_req, optionally delayed by 'stall'.
  always @(negedge clk) begin
    if (rst) mem.ready = 1'b0;
    else if (mem.ready) mem.ready = 1'b0;
    else if (mem.req) begin
      if (stall > 0) stall = stall - 1;
      else begin
        mem.ready = 1'b1;
        mem.rdata = mem_val(mem.addr);
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && mem.req && mem.ready) begin
      if (mem.we) begin
        wb_count = wb_count + 1;
        wb_addr  = mem.addr;
        wb_data  = mem.wdata;
        wb_cyc   = cyc;
      end else begin
        refill_addr = mem.addr;
        refill_cyc  = cyc;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    cpu.req = 1'b0;
    stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input vec_t v, input string nm);
    int n;
    cpu.req = 1'b1; cpu.we = v.we; cpu.addr = v.addr; cpu.wdata = v.wdata;
    n = 0;
    while (!cpu.ready && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    cpu.req = 1'b0;
    n = 0;
    while (!cpu.resp_valid && n < 50) begin @(negedge clk); #1; n++; end
    check({nm, " resp_valid"}, {31'd0, cpu.resp_valid}, 32'd1);
    check({nm, " hit"}, {31'd0, cpu.hit}, {31'd0, v.exp_hit});
    check({nm, " rdata"}, cpu.rdata, v.exp_rdata);
    check({nm, " hit_count"}, {28'd0, hit_count}, 32'(v.exp_hits));
    check({nm, " miss_count"}, {28'd0, miss_count}, 32'(v.exp_misses));
    if (!v.exp_hit) check({nm, " refill addr"}, {21'd0, refill_addr}, {21'd0, v.addr[10:5], 5'd0});
  endtask

  initial begin
    int n;
    int wb_before;
    logic seen;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    mem.ready = 1'b0; mem.rdata = '0;

    vecs[0]  = mk(0, 0, 11'h000, 32'h0,        0, 32'h11111111, 0, 1);
    vecs[1]  = mk(0, 0, 11'h000, 32'h0,        1, 32'h11111111, 1, 1);
    vecs[2]  = mk(0, 0, 11'h000, 32'h0,        1, 32'h11111111, 2, 1);
    vecs[3]  = mk(0, 0, 11'h080, 32'h0,        0, 32'h22222222, 2, 2);
    vecs[4]  = mk(0, 0, 11'h100, 32'h0,        0, 32'h33333333, 2, 3);
    vecs[5]  = mk(0, 0, 11'h180, 32'h0,        0, 32'h44444444, 2, 4);
    vecs[6]  = mk(0, 0, 11'h000, 32'h0,        1, 32'h11111111, 3, 4);
    vecs[7]  = mk(0, 0, 11'h200, 32'h0,        0, 32'h55555555, 3, 5);
    vecs[8]  = mk(0, 0, 11'h080, 32'h0,        0, 32'h22222222, 3, 6);
    vecs[9]  = mk(0, 0, 11'h000, 32'h0,        1, 32'h11111111, 4, 6);
    vecs[10] = mk(0, 0, 11'h200, 32'h0,        1, 32'h55555555, 5, 6);
    vecs[11] = mk(1, 1, 11'h000, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 1);
    vecs[12] = mk(0, 0, 11'h080, 32'h0,        0, 32'h22222222, 0, 2);
    vecs[13] = mk(0, 0, 11'h100, 32'h0,        0, 32'h33333333, 0, 3);
    vecs[14] = mk(0, 0, 11'h180, 32'h0,        0, 32'h44444444, 0, 4);
    vecs[15] = mk(0, 1, 11'h100, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 4);
    vecs[16] = mk(0, 0, 11'h100, 32'h0,        1, 32'hDEADBEEF, 2, 4);
    vecs[17] = mk(0, 0, 11'h280, 32'h0,        0, 32'h66666666, 2, 5);

    // Reset state
    @(negedge clk); #1;
    check("reset cpu_ready", {31'd0, cpu.ready}, 32'd1);
    check("reset outputs", {cpu.resp_valid, cpu.hit, mem.req, mem.we, 20'd0, hit_count, miss_count}, 32'd0);
    check("reset rdata", cpu.rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // LRU, hit/miss and dirty-eviction sequences
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rst_before) apply_reset();
      do_req(vecs[i], $sformatf("v%0d", i));
    end
    check("wb count", 32'(wb_count), 32'd1);
    check("wb addr", {21'd0, wb_addr}, 32'h000);
    check("wb data", wb_data, 32'hCAFEF00D);
    check("wb before refill", {31'd0, wb_cyc < refill_cyc}, 32'd1);

    // Stalled refill; held cpu_req must be ignored
    apply_reset();
    stall = 5;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 11'h000; cpu.wdata = '0;
    @(posedge clk); #1;
    cpu.addr = 11'h080;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("stall cycle %0d", k),
            {mem.req, cpu.ready, cpu.resp_valid, 18'd0, mem.addr}, {1'b1, 1'b0, 1'b0, 18'd0, 11'h000});
    end
    n = 0;
    while (!cpu.resp_valid && n < 20) begin @(negedge clk); #1; n++; end
    cpu.req = 1'b0;
    check("stall resp_valid", {31'd0, cpu.resp_valid}, 32'd1);
    check("stall resp latency", 32'(cyc - refill_cyc), 32'd0);
    check("stall rdata", cpu.rdata, 32'h11111111);
    check("stall mem_req dropped", {31'd0, mem.req}, 32'd0);
    check("stall miss_count", {28'd0, miss_count}, 32'd1);

    // Reset asserted while a write-back is pending
    apply_reset();
    do_req(mk(0, 1, 11'h000, 32'hAAAA5555, 0, 32'hAAAA5555, 0, 1), "t5 w000");
    do_req(mk(0, 0, 11'h080, 32'h0, 0, 32'h22222222, 0, 2), "t5 r080");
    do_req(mk(0, 0, 11'h100, 32'h0, 0, 32'h33333333, 0, 3), "t5 r100");
    do_req(mk(0, 0, 11'h180, 32'h0, 0, 32'h44444444, 0, 4), "t5 r180");
    wb_before = wb_count;
    stall = 10;
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 11'h280;
    @(posedge clk); #1;
    cpu.req = 1'b0;
    n = 0;
    while (!(mem.req && mem.we) && n < 20) begin @(negedge clk); #1; n++; end
    check("t5 in WB", {31'd0, mem.req && mem.we}, 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t5 mem_req after rst", {31'd0, mem.req}, 32'd0);
    check("t5 cpu_ready after rst", {31'd0, cpu.ready}, 32'd1);
    rst = 1'b0;
    stall = 0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (cpu.resp_valid) seen = 1'b1;
    end
    check("t5 no response", {31'd0, seen}, 32'd0);
    do_req(mk(0, 0, 11'h000, 32'h0, 0, 32'h11111111, 0, 1), "t5 r000");
    check("t5 no wb", 32'(wb_count - wb_before), 32'd0);

    // Counter saturation
    apply_reset();
    do_req(mk(0, 0, 11'h000, 32'h0, 0, 32'h11111111, 0, 1), "t6 miss");
    for (int i = 1; i <= 20; i++)
      do_req(mk(0, 0, 11'h000, 32'h0, 1, 32'h11111111, (i > 15) ? 15 : i, 1), $sformatf("t6 hit%0d", i));
    check("t6 hit_count sat", {28'd0, hit_count}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_nway_wb.md
Name: cache_nway_wb

Overview:
Parametrised N-way set-associative cache. Supports reads and writes, write-back/write-allocate, true-LRU replacement and saturating hit/miss counters. Sits between a requester (CPU-side valid/ready port) and a slower next-level memory (req/ready port). It is the successor to the fixed 4-way read-only L2 model: misses now become real multi-cycle memory transactions instead of filling lines with a constant.

Parameters:
ADDR_WIDTH, 11, byte address width
DATA_WIDTH, 32, word width; each line holds one word
CACHE_SIZE, 512, total capacity in bytes (sizing only)
BLOCK_SIZE, 32, line size in bytes; sets the offset width only
NUM_WAYS, 4, associativity; power of two, 2..16
CNT_WIDTH, 16, width of the hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_req  in  1  request valid
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  request address
cpu_wdata  in  DATA_WIDTH  write data
cpu_ready  out  1  request accepted when cpu_req && cpu_ready at clk edge
cpu_resp_valid  out  1  one-cycle response strobe
cpu_rdata  out  DATA_WIDTH  read data (for writes: the newly written word)
cpu_hit  out  1  response was a hit; qualified by cpu_resp_valid
mem_req  out  1  memory request valid
mem_we  out  1  1 = write-back, 0 = refill read
mem_addr  out  ADDR_WIDTH  line address (offset bits zero)
mem_wdata  out  DATA_WIDTH  evicted line data
mem_ready  in  1  memory completes the transaction at clk edge when mem_req && mem_ready
mem_rdata  in  DATA_WIDTH  refill data, valid with mem_ready
hit_count  out  CNT_WIDTH  accepted requests that hit; saturates at all-ones
miss_count  out  CNT_WIDTH  accepted requests that missed; saturates

Behaviour:
- Geometry:
  - NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS)
  - index = addr[OFFSET_W +: INDEX_W]
  - tag = addr upper TAG_W bits
- Per line state: valid, dirty, tag, data.
- Per set LRU state: one age field of clog2(NUM_WAYS) bits per way. Age 0 = MRU. Ages within a set are always a permutation of 0..NUM_WAYS-1.
- Reset: all valid/dirty = 0, tags/data = 0, ages = way index, state = IDLE. All outputs 0 except cpu_ready = 1.
- Reset mid-transaction: abort immediately and drop mem_req. Dirty data is lost; no response is issued.
- FSM states: IDLE, WB, REFILL.
- IDLE:
  - cpu_ready = 1; tag compare runs combinationally on cpu_addr.
  - Hit: next edge updates LRU (hit way to 0; ways younger than it +1). Write hit stores cpu_wdata and sets dirty. cpu_resp_valid=1 and cpu_hit=1 in the following cycle. Latency 1 cycle; back-to-back hits allowed.
  - Miss: latch the request and increment miss_count. Go to WB if the victim is valid and dirty, else REFILL. cpu_ready drops the next cycle.
- Victim selection: lowest-index invalid way, else the way with age NUM_WAYS-1.
- WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim data.
  - All held stable until mem_ready, then go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={latched tag, index, 0}.
  - On mem_ready, install the line in the victim way: valid=1 and victim made MRU.
  - Read miss: data=mem_rdata, dirty=0.
  - Write miss: data=cpu_wdata (word-granular merge), dirty=1.
  - Next cycle: cpu_resp_valid=1, cpu_hit=0, cpu_rdata=installed word; state returns to IDLE.
- mem_req deasserts the cycle after completion; never asserted in IDLE.
- mem_ready while mem_req=0 is ignored.
- cpu_req while cpu_ready=0 is ignored; the requester must hold it.
- cpu_rdata holds its last value between responses.
- Counters increment only on acceptance and saturate, never wrap.

Decomposition:
- Shared header cache_defs.vh holds:
  - FSM state encodings (IDLE=0, WB=1, REFILL=2)
  - the geometry localparam derivations (NUM_SETS, INDEX_W, OFFSET_W, TAG_W), so L1/L2 variants agree.
- Sub-module lru_age_nway: one set's age vector. Inputs touch_en and touch_way; outputs victim_way (oldest) and the updated age vector.

Test Plan (defaults, 4 sets, tag=addr[10:7]; mem_ready one cycle after mem_req):
1. After reset, read 0x000 -> REFILL with mem_addr=0x000; memory returns 0x11111111 -> resp hit=0, rdata=0x11111111, miss_count=1. Read 0x000 again -> resp next cycle, hit=1, hit_count=1.
2. Read 0x000, 0x080, 0x100, 0x180, then re-read 0x000 (hit), then read 0x200 -> victim is 0x080's way (oldest); refill mem_addr=0x200; re-read 0x080 -> miss.
3. Write 0x000 with 0xCAFEF00D (miss, allocate, dirty), fill set 0 so 0x000 becomes oldest, then read 0x280 -> WB phase mem_we=1, mem_addr=0x000, mem_wdata=0xCAFEF00D, followed by REFILL of 0x280.
4. Hold mem_ready=0 for 5 cycles during REFILL -> mem_req/mem_addr stable, cpu_ready=0, incoming cpu_req ignored; response one cycle after mem_ready.
5. Assert rst during WB -> next cycle mem_req=0, cpu_ready=1, no response; read 0x000 -> miss.
6. Force counters near all-ones (CNT_WIDTH=4, 20 hits) -> hit_count holds 15.
